// File: rtl/systolic_a_skewer_if.sv
// Bus bundle for the A-operand skew buffer: tile-row writes, drain advance,
// and the skewed lanes that feed the left column of MAC cells.
interface systolic_a_skewer_if #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8,
    parameter int ROWBITS = $clog2(DIM)
) ();
    logic                             en;
    logic                             WrEn;
    logic [ROWBITS-1:0]               Arow;
    logic [DIM-1:0][BITS_AB-1:0]      Ain;
    logic [DIM-1:0][BITS_AB-1:0]      Aout;
    logic                             drain_done;

    modport master (
        output en, WrEn, Arow, Ain,
        input  Aout, drain_done
    );

    modport slave (
        input  en, WrEn, Arow, Ain,
        output Aout, drain_done
    );
endinterface

// File: rtl/systolic_a_skewer.sv
// Holds one DIM x DIM tile of A and drains it diagonally skewed so that
// lane r lags lane 0 by r cycles. Data passes through bit-exact.
module systolic_a_skewer #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8,
    parameter int ROWBITS = $clog2(DIM)
) (
    input  logic             clk,
    input  logic             rst_n,
    systolic_a_skewer_if.slave bus
);
    localparam int TW   = (DIM > 1) ? $clog2(2 * DIM - 1) : 1;
    localparam int TMAX = 2 * DIM - 2;

    logic [DIM-1:0][BITS_AB-1:0] mem [DIM];
    logic [TW-1:0]               t;
    logic [DIM-1:0][BITS_AB-1:0] lane_next;
    logic [DIM-1:0][BITS_AB-1:0] aout_q;
    logic                        done_q;
    logic                        row_ok;
    logic                        last_step;

    assign row_ok    = ({1'b0, bus.Arow} < (ROWBITS + 1)'(DIM));
    assign last_step = (t == TW'(TMAX));

    // Lane r shows column t-r of its row while that column exists, else zero.
    for (genvar r = 0; r < DIM; r++) begin : g_lane
        logic [TW-1:0] col_full;
        logic          in_win;

        assign col_full     = t - TW'(r);
        assign in_win       = (t >= TW'(r)) && (col_full < TW'(DIM));
        assign lane_next[r] = in_win ? mem[r][col_full[ROWBITS-1:0]] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DIM; r++) begin
                mem[r] <= '0;
            end
            t      <= '0;
            aout_q <= '0;
            done_q <= 1'b0;
        end else begin
            // Drain reads the pre-edge contents, so a row may be refilled behind the front.
            if (bus.WrEn && row_ok) begin
                mem[bus.Arow] <= bus.Ain;
            end
            if (bus.en) begin
                aout_q <= lane_next;
                t      <= last_step ? '0 : t + 1'b1;
                done_q <= last_step;
            end else begin
                done_q <= 1'b0;
            end
        end
    end

    assign bus.Aout       = aout_q;
    assign bus.drain_done = done_q;
endmodule

// File: tb/tb_systolic_a_skewer.sv
// Self-checking bench for systolic_a_skewer: literal vector tables, corner
// sequences and randomized traffic against a tile/step reference model.
module tb_systolic_a_skewer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    systolic_a_skewer_if #(.BITS_AB(8), .DIM(4), .ROWBITS(2)) bus4 ();
    systolic_a_skewer_if #(.BITS_AB(8), .DIM(3), .ROWBITS(2)) bus3 ();

    systolic_a_skewer #(.BITS_AB(8), .DIM(4), .ROWBITS(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4)
    );
    systolic_a_skewer #(.BITS_AB(8), .DIM(3), .ROWBITS(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model of the DIM=4 instance: the tile, the step index and
    // the expected output of the most recent edge.
    logic [7:0]       m4 [4][4];
    int               mt;
    logic [3:0][7:0]  exp_a;
    logic             exp_d;

    typedef struct {
        bit          en;
        bit          wr;
        logic [1:0]  ar;
        logic [31:0] d;
        logic [31:0] ea;
        bit          ed;
    } vec_t;

    vec_t        tbl [11];
    logic [31:0] drain_seq [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m4[r][c] = 8'h00;
        mt    = 0;
        exp_a = '0;
        exp_d = 1'b0;
    endtask

    task automatic model_edge(input bit e, input bit w, input logic [1:0] ar, input logic [31:0] d);
        if (e) begin
            for (int r = 0; r < 4; r++) begin
                int k;
                k = mt - r;
                exp_a[r] = (k >= 0 && k < 4) ? m4[r][k] : 8'h00;
            end
            exp_d = (mt == 6);
            mt    = (mt == 6) ? 0 : mt + 1;
        end else begin
            exp_d = 1'b0;
        end
        if (w)
            for (int c = 0; c < 4; c++)
                m4[ar][c] = d[8*c +: 8];
    endtask

    task automatic step4(input bit e, input bit w, input logic [1:0] ar, input logic [31:0] d);
        @(negedge clk);
        bus4.en   = e;
        bus4.WrEn = w;
        bus4.Arow = ar;
        bus4.Ain  = d;
        @(posedge clk);
        model_edge(e, w, ar, d);
        #1;
        chk("model_aout", bus4.Aout, exp_a);
        chk("model_done", {31'b0, bus4.drain_done}, {31'b0, exp_d});
    endtask

    task automatic step3(input bit e, input bit w, input logic [1:0] ar, input logic [23:0] d,
                         input logic [23:0] ea, input bit ed);
        @(negedge clk);
        bus3.en   = e;
        bus3.WrEn = w;
        bus3.Arow = ar;
        bus3.Ain  = d;
        @(posedge clk);
        #1;
        chk("dim3_aout", {8'h00, bus3.Aout}, {8'h00, ea});
        chk("dim3_done", {31'b0, bus3.drain_done}, {31'b0, ed});
    endtask

    task automatic load_tile();
        step4(0, 1, 2'd0, 32'h03020100);
        step4(0, 1, 2'd1, 32'h13121110);
        step4(0, 1, 2'd2, 32'h23222120);
        step4(0, 1, 2'd3, 32'h33323130);
    endtask

    initial begin
        drain_seq[0] = 32'h00000000;
        drain_seq[1] = 32'h00001001;
        drain_seq[2] = 32'h00201102;
        drain_seq[3] = 32'h30211203;
        drain_seq[4] = 32'h31221300;
        drain_seq[5] = 32'h32230000;
        drain_seq[6] = 32'h33000000;

        tbl[0] = '{0, 1, 2'd0, 32'h03020100, 32'h0, 0};
        tbl[1] = '{0, 1, 2'd1, 32'h13121110, 32'h0, 0};
        tbl[2] = '{0, 1, 2'd2, 32'h23222120, 32'h0, 0};
        tbl[3] = '{0, 1, 2'd3, 32'h33323130, 32'h0, 0};
        for (int i = 0; i < 7; i++)
            tbl[4 + i] = '{1, 0, 2'd0, 32'h0, drain_seq[i], (i == 6)};

        bus4.en = 0; bus4.WrEn = 0; bus4.Arow = '0; bus4.Ain = '0;
        bus3.en = 0; bus3.WrEn = 0; bus3.Arow = '0; bus3.Ain = '0;
        model_reset();

        // Reset state
        #1;
        chk("reset_aout", bus4.Aout, 32'h0);
        chk("reset_done", {31'b0, bus4.drain_done}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Load and drain from the vector table
        for (int i = 0; i < 11; i++) begin
            step4(tbl[i].en, tbl[i].wr, tbl[i].ar, tbl[i].d);
            chk($sformatf("tbl_aout[%0d]", i), bus4.Aout, tbl[i].ea);
            chk($sformatf("tbl_done[%0d]", i), {31'b0, bus4.drain_done}, {31'b0, tbl[i].ed});
        end

        // en stall after step t2
        for (int i = 0; i < 3; i++) step4(1, 0, 2'd0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step4(0, 0, 2'd0, 32'h0);
            chk("stall_hold", bus4.Aout, 32'h00201102);
            chk("stall_done", {31'b0, bus4.drain_done}, 32'h0);
        end
        step4(1, 0, 2'd0, 32'h0);
        chk("stall_resume_t3", bus4.Aout, 32'h30211203);
        for (int i = 4; i < 7; i++) step4(1, 0, 2'd0, 32'h0);
        chk("stall_done_t6", {31'b0, bus4.drain_done}, 32'h1);

        // Writes behind the drain front
        step4(1, 0, 2'd0, 32'h0);
        step4(1, 1, 2'd3, 32'hDDCCBBAA);
        step4(1, 1, 2'd0, 32'h44332211);
        chk("wdrain_t2_lane0_old", {24'h0, bus4.Aout[0]}, 32'h02);
        step4(1, 0, 2'd0, 32'h0);
        chk("wdrain_t3_lane3", {24'h0, bus4.Aout[3]}, 32'hAA);
        chk("wdrain_t3_lane0", {24'h0, bus4.Aout[0]}, 32'h44);
        step4(1, 0, 2'd0, 32'h0);
        step4(1, 0, 2'd0, 32'h0);
        step4(1, 0, 2'd0, 32'h0);
        chk("wdrain_t6_lane3", {24'h0, bus4.Aout[3]}, 32'hDD);

        // Back-to-back drains of the same tile
        load_tile();
        for (int i = 0; i < 14; i++) begin
            step4(1, 0, 2'd0, 32'h0);
            chk($sformatf("b2b_aout[%0d]", i), bus4.Aout, drain_seq[i % 7]);
            chk($sformatf("b2b_done[%0d]", i), {31'b0, bus4.drain_done}, {31'b0, (i % 7) == 6});
        end

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++)
            step4($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  2'($urandom_range(0, 3)), $urandom);

        // Reset mid-drain at t=3
        while (mt != 0) step4(1, 0, 2'd0, 32'h0);
        load_tile();
        for (int i = 0; i < 3; i++) step4(1, 0, 2'd0, 32'h0);
        chk("pre_reset_t2", bus4.Aout, 32'h00201102);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midreset_aout", bus4.Aout, 32'h0);
        chk("midreset_done", {31'b0, bus4.drain_done}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step4(1, 0, 2'd0, 32'h0);
        chk("postreset_t0", bus4.Aout, 32'h0);
        step4(1, 0, 2'd0, 32'h0);
        chk("postreset_cleared", bus4.Aout, 32'h0);

        // DIM=3: out-of-range row ignored, negative bytes pass bit-exact
        step3(0, 1, 2'd0, 24'h01FF80, 24'h0, 0);
        step3(0, 1, 2'd1, 24'hFF807F, 24'h0, 0);
        step3(0, 1, 2'd2, 24'h8002FE, 24'h0, 0);
        step3(0, 1, 2'd3, 24'h555555, 24'h0, 0);
        step3(1, 0, 2'd0, 24'h0, 24'h000080, 0);
        step3(1, 0, 2'd0, 24'h0, 24'h007FFF, 0);
        step3(1, 0, 2'd0, 24'h0, 24'hFE8001, 0);
        step3(1, 0, 2'd0, 24'h0, 24'h02FF00, 0);
        step3(1, 0, 2'd0, 24'h0, 24'h800000, 1);
        step3(1, 0, 2'd0, 24'h0, 24'h000080, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/systolic_a_skewer.md
Name: systolic_a_skewer

Overview:
- Input staging buffer that sits directly upstream of the left column of tpumac cells in the systolic array.
- Holds one DIM x DIM tile of matrix A, loaded one row per write.
- On drain, emits A diagonally skewed: row r is delayed r cycles relative to row 0. Each cycle, Aout[r] drives the Ain port of the first MAC cell in array row r.
- Data is passed through bit-exact; signed interpretation belongs to the MAC cells.

Parameters:
- BITS_AB, 8, width of each A element (matches MAC Ain width).
- DIM, 8, array dimension: rows/columns of the stored tile and number of output lanes.
- ROWBITS, $clog2(DIM), width of the row-select port.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  drain advance; one skew step per cycle while high.
- WrEn  input  1  write one tile row this cycle.
- Arow  input  ROWBITS  row index for write; values >= DIM ignore the write.
- Ain  input  DIM x BITS_AB  row data; Ain[c] is written to M[Arow][c].
- Aout  output  DIM x BITS_AB  skewed lanes; Aout[r] feeds array row r.
- drain_done  output  1  one-cycle pulse on the final drain step.

Behaviour:
- Storage: M[DIM][DIM] of BITS_AB bits. Drain counter t ranges 0..2*DIM-2 (width $clog2(2*DIM-1)).
- Reset (async, rst_n low): every M entry = 0, t = 0, Aout all lanes = 0, drain_done = 0. Reset is effective immediately and holds while low. Reset asserted mid-drain aborts the drain; t restarts at 0.
- Write, posedge with WrEn=1 and Arow<DIM: M[Arow][c] <= Ain[c] for all c. No other state changes. Arow>=DIM: no effect.
- Drain step, posedge with en=1, all in the same edge:
  - for each r: Aout[r] <= M[r][t-r] if r <= t <= r+DIM-1, else 0;
  - t <= (t == 2*DIM-2) ? 0 : t+1;
  - drain_done <= (t == 2*DIM-2).
- en=0: Aout and t hold their values; drain_done <= 0.
- Latency: the first element M[0][0] appears on Aout[0] one clock after the first en edge. A full tile drains in 2*DIM-1 en cycles. Row r's last element M[r][DIM-1] appears at step t = r+DIM-1.
- en may drop mid-drain. Skew state is preserved, and resuming continues at the same t with no bubbles inserted.
- Simultaneous WrEn and en on the same edge: both take effect. The drain read uses M values from before the edge (old data); the write is visible to later steps. This permits loading the next tile row-by-row behind the drain front.
- Back-to-back drains: after wrap (t=0), en continuing high starts a new tile immediately. Step 0 of the new drain outputs the lane-0 value for t=0; other lanes output 0.
- No handshake back-pressure: the consumer (MAC array) is assumed to advance on the same en.
- Output values are registers only; there is no combinational path from inputs to Aout.

Test Plan:
- Reset check (DIM=4): load arbitrary data, assert rst_n=0 mid-drain at t=3 -> Aout immediately all 0 and drain_done=0. After release, the next en step outputs {M[0][0]=0,0,0,0}, since M was cleared, and t restarts.
- Load and drain (DIM=4): write rows r=0..3 with Ain[c]=16*r+c, then en high for 7 cycles -> Aout lanes [0..3] per step:
  - t0 {00,00,00,00}
  - t1 {01,10,00,00}
  - t2 {02,11,20,00}
  - t3 {03,12,21,30}
  - t4 {00,13,22,31}
  - t5 {00,00,23,32}
  - t6 {00,00,00,33}, with drain_done=1 only on the t6 step.
- en stall: same tile, drop en for 3 cycles after step t2 -> Aout holds {02,11,20,00} and drain_done stays 0. On resume the next step is t3 {03,12,21,30}.
- Write during drain: at the t1 edge, also WrEn with Arow=3, Ain={AA,BB,CC,DD} -> step t3 lane 3 = AA (new data, written before it is read), and t6 lane 3 = DD. Writing row 0 at step t2 -> t3 lane 0 = new Ain[3] value.
- Out-of-range and signed data: with DIM=4 and ROWBITS=2 no out-of-range Arow exists, so use DIM=3 (ROWBITS=2) and write Arow=3 -> M unchanged. Load negative bytes (0x80, 0xFF) -> emitted bit-exact, no sign alteration.
- Back-to-back: hold en high for 14 cycles over two identical tiles -> two identical 7-step sequences with no gap, and drain_done high on steps 6 and 13.
